// File: rtl/adc_conv_sequencer.sv
// ADC conversion sequencer: power-up delay, paced CONVST pulses,
// EOC wait with timeout, delayed DB capture and overrun/timeout flags.
module adc_conv_sequencer #(
  parameter int PWRUP_CYCLES  = 10000,
  parameter int SAMPLE_PERIOD = 100,
  parameter int CONVST_LOW    = 5,
  parameter int CAPTURE_DLY   = 6,
  parameter int EOC_TIMEOUT   = 200
) (
  input  logic        clk_100M,
  input  logic        Reset,
  input  logic        enable,
  input  logic        EOC_18,
  input  logic [7:0]  DB_in,
  output logic        PD_in,
  output logic        CONVST_in,
  output logic [7:0]  sample_data,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout_err,
  output logic [15:0] sample_count
);

  typedef enum logic [2:0] {
    S_OFF,
    S_PWRUP,
    S_IDLE,
    S_CONV,
    S_WAIT,
    S_READ
  } state_e;

  localparam int CM0 =
    PWRUP_CYCLES > EOC_TIMEOUT ? PWRUP_CYCLES : EOC_TIMEOUT;
  localparam int CM1 =
    CONVST_LOW > CAPTURE_DLY ? CONVST_LOW : CAPTURE_DLY;
  localparam int CMAX = CM0 > CM1 ? CM0 : CM1;
  localparam int CW = $clog2(CMAX + 1);
  localparam int PW = $clog2(SAMPLE_PERIOD);

  localparam logic [CW-1:0] PWR_LAST  = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONVST_LOW - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(EOC_TIMEOUT - 1);
  localparam logic [CW-1:0] CAP_LAST  = CW'(CAPTURE_DLY - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          tmo_q, tmo_d;
  logic [15:0]   count_q, count_d;
  logic          eoc_m_q, eoc_s_q, eoc_s_d1_q;
  logic          eoc_fall;
  logic          busy_w;

  // EOC is asynchronous; idle-high reset keeps a false fall from firing
  always_ff @(posedge clk_100M or negedge Reset) begin
    if (!Reset) begin
      eoc_m_q    <= 1'b1;
      eoc_s_q    <= 1'b1;
      eoc_s_d1_q <= 1'b1;
    end else begin
      eoc_m_q    <= EOC_18;
      eoc_s_q    <= eoc_m_q;
      eoc_s_d1_q <= eoc_s_q;
    end
  end

  assign eoc_fall = eoc_s_d1_q & ~eoc_s_q;
  assign busy_w   = (state_q == S_CONV) ||
                    (state_q == S_WAIT) ||
                    (state_q == S_READ);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ovr_d   = ovr_q;
    tmo_d   = tmo_q;
    count_d = count_q;
    // period keeps running through a conversion; pinned at expiry
    if (busy_w) begin
      if (per_q == PER_LAST) ovr_d = 1'b1;
      else                   per_d = per_q + 1'b1;
    end
    unique case (state_q)
      S_OFF: begin
        if (enable) begin
          state_d = S_PWRUP;
          cnt_d   = '0;
        end
      end
      S_PWRUP: begin
        if (!enable) begin
          state_d = S_OFF;
        end else if (cnt_q == PWR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          per_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (!enable) begin
          state_d = S_OFF;
        end else if (per_q == PER_LAST) begin
          state_d = S_CONV;
          cnt_d   = '0;
          per_d   = '0;
        end else begin
          per_d = per_q + 1'b1;
        end
      end
      S_CONV: begin
        if (cnt_q == CONV_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (eoc_fall) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (cnt_q == CAP_LAST) begin
          data_d  = DB_in;
          valid_d = 1'b1;
          count_d = count_q + 16'd1;
          state_d = enable ? S_IDLE : S_OFF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk_100M or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      per_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      count_q <= count_d;
    end
  end

  assign PD_in        = (state_q != S_OFF);
  assign CONVST_in    = (state_q != S_CONV);
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign busy         = busy_w;
  assign overrun      = ovr_q;
  assign timeout_err  = tmo_q;
  assign sample_count = count_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Bench for adc_conv_sequencer: directed table, timeline
// reference model with random EOC latency, enable-drop and reset.
module tb_adc_conv_sequencer;

  localparam int PWRUP  = 10000;
  localparam int PERIOD = 100;
  localparam int LOWW   = 5;
  localparam int SYNC   = 2;
  localparam int CAPD   = 6;
  localparam int TOUT   = 200;

  logic        clk_100M = 1'b0;
  logic        Reset    = 1'b0;
  logic        enable   = 1'b0;
  logic        EOC_18   = 1'b1;
  logic [7:0]  DB_in    = 8'h00;
  logic        PD_in;
  logic        CONVST_in;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic        timeout_err;
  logic [15:0] sample_count;

  adc_conv_sequencer dut (
    .clk_100M    (clk_100M),
    .Reset       (Reset),
    .enable      (enable),
    .EOC_18      (EOC_18),
    .DB_in       (DB_in),
    .PD_in       (PD_in),
    .CONVST_in   (CONVST_in),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .sample_count(sample_count)
  );

  always #5 clk_100M = ~clk_100M;

  typedef struct {
    int         lat;
    bit         has;
    logic [7:0] db;
    int         exp_sv;
    int         exp_nx;
    bit         exp_ovr;
    bit         exp_tmo;
  } vec_t;

  vec_t tbl[6];
  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int m_count = 0;
  bit m_ovr = 0;
  bit m_tmo = 0;

  task automatic tick();
    @(posedge clk_100M);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // End of conversion offset: sample edge, or timeout return
  function automatic int m_end(input int lat, input bit has);
    return has ? lat + SYNC + CAPD : LOWW + TOUT;
  endfunction

  function automatic int m_next(input int lat, input bit has);
    int e;
    e = m_end(lat, has);
    return (e + 1 > PERIOD) ? e + 1 : PERIOD;
  endfunction

  task automatic wait_fall(input int bound, output int at);
    at = -1;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (!CONVST_in) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Entered on the cycle CONVST_in has just fallen
  task automatic do_conv(input int lat, input bit has,
                         input logic [7:0] db, input int drop,
                         input int exp_sv, input int exp_nx);
    int low, nval, sv, nx, got;
    logic prev;
    low = 0; nval = 0; sv = -1; nx = -1; got = -1;
    prev = 1'b0;
    DB_in = db;
    chk("busy_conv", busy, 1);
    for (int k = 0; k < 300; k++) begin
      if (k > 0 && !CONVST_in && prev) begin
        nx = k;
        break;
      end
      if (!CONVST_in) low++;
      if (sample_valid) begin
        nval++;
        sv  = k;
        got = sample_data;
      end
      if (has && k == lat - 1) EOC_18 = 1'b0;
      if (has && k == lat + 2) EOC_18 = 1'b1;
      if (k == drop) enable = 1'b0;
      prev = CONVST_in;
      tick();
    end
    chk("convst_width", low, LOWW);
    chk("valid_pulses", nval, has ? 1 : 0);
    if (has) begin
      chk("valid_at", sv, exp_sv);
      chk("sample_data", got, int'(db));
    end
    chk("next_fall", nx, exp_nx == 0 ? -1 : exp_nx);
  endtask

  task automatic conv_model(input int lat, input bit has);
    logic [7:0] db;
    db = 8'($urandom_range(0, 255));
    do_conv(lat, has, db, -1,
            has ? m_end(lat, has) : 0, m_next(lat, has));
    m_count += has ? 1 : 0;
    m_ovr |= (m_end(lat, has) >= PERIOD);
    m_tmo |= !has;
    chk("overrun", overrun, m_ovr);
    chk("timeout_err", timeout_err, m_tmo);
    chk("sample_count", sample_count, m_count);
  endtask

  initial begin
    int t0, at, lat;
    bit has;
    tbl[0] = '{40,  1'b1, 8'hA5, 48,  100, 1'b0, 1'b0};
    tbl[1] = '{10,  1'b1, 8'h3C, 18,  100, 1'b0, 1'b0};
    tbl[2] = '{91,  1'b1, 8'h5A, 99,  100, 1'b0, 1'b0};
    tbl[3] = '{92,  1'b1, 8'hC3, 100, 101, 1'b1, 1'b0};
    tbl[4] = '{0,   1'b0, 8'h00, 0,   206, 1'b1, 1'b1};
    tbl[5] = '{150, 1'b1, 8'h7E, 158, 159, 1'b1, 1'b1};

    #23;
    chk("rst_pd", PD_in, 0);
    chk("rst_convst", CONVST_in, 1);
    chk("rst_data", sample_data, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_count", sample_count, 0);
    Reset = 1'b1;
    tick();
    tick();
    chk("off_pd", PD_in, 0);

    enable = 1'b1;
    t0 = cyc;
    tick();
    chk("pd_rise", PD_in, 1);
    wait_fall(PWRUP + PERIOD + 50, at);
    chk("first_conv", at < 0 ? -1 : at - (t0 + 1), PWRUP + PERIOD);

    // first sample, then a steady randomized run to 20 samples
    do_conv(tbl[0].lat, tbl[0].has, tbl[0].db, -1,
            tbl[0].exp_sv, tbl[0].exp_nx);
    m_count++;
    chk("count_first", sample_count, m_count);
    for (int i = 1; i < 20; i++) begin
      conv_model($urandom_range(10, 90), 1'b1);
    end
    chk("steady_count", sample_count, 20);
    chk("steady_ovr", overrun, 0);

    for (int i = 1; i < 6; i++) begin
      do_conv(tbl[i].lat, tbl[i].has, tbl[i].db, -1,
              tbl[i].exp_sv, tbl[i].exp_nx);
      m_count += tbl[i].has ? 1 : 0;
      chk("tbl_ovr", overrun, tbl[i].exp_ovr);
      chk("tbl_tmo", timeout_err, tbl[i].exp_tmo);
      chk("tbl_count", sample_count, m_count);
    end
    m_ovr = 1'b1;
    m_tmo = 1'b1;

    for (int i = 0; i < 10; i++) begin
      has = ($urandom_range(0, 4) != 0);
      lat = $urandom_range(10, 150);
      conv_model(lat, has);
    end

    // enable drops in WAIT_EOC: sample delivered, then powered down
    do_conv(40, 1'b1, 8'h96, 20, 48, 0);
    m_count++;
    chk("drop_count", sample_count, m_count);
    chk("drop_pd", PD_in, 0);
    chk("drop_convst", CONVST_in, 1);
    chk("drop_busy", busy, 0);

    enable = 1'b1;
    t0 = cyc;
    wait_fall(PWRUP + PERIOD + 50, at);
    chk("repwr_conv", at < 0 ? -1 : at - (t0 + 1), PWRUP + PERIOD);
    DB_in = 8'h33;
    for (int k = 0; k < 44; k++) begin
      if (k == 39) EOC_18 = 1'b0;
      if (k == 42) EOC_18 = 1'b1;
      tick();
    end
    chk("read_busy", busy, 1);
    Reset = 1'b0;
    #1;
    chk("mid_pd", PD_in, 0);
    chk("mid_convst", CONVST_in, 1);
    chk("mid_data", sample_data, 0);
    chk("mid_valid", sample_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ovr", overrun, 0);
    chk("mid_tmo", timeout_err, 0);
    chk("mid_count", sample_count, 0);
    enable = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    chk("post_pd", PD_in, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
